// File: rtl/rv64g_l1_resp_gather_if.sv
// Bundle between the bank array, the request-side arming logic and the VLSU
// for the L1 vector response gather.
interface rv64g_l1_resp_gather_if #(
    parameter int NUM_LANES = 8,
    parameter int NUM_BANKS = 8
);
    logic                      arm_i;
    logic                      arm_ready_o;
    logic [NUM_LANES-1:0]      arm_lane_valid_i;
    logic [NUM_LANES-1:0]      arm_lane_we_i;
    logic [NUM_LANES*3-1:0]    arm_lane_off_i;
    logic [NUM_LANES*2-1:0]    arm_lane_size_i;
    logic [NUM_LANES-1:0]      arm_lane_signed_i;
    logic [NUM_BANKS-1:0]      bank_rvalid_i;
    logic [NUM_BANKS*64-1:0]   bank_rdata_i;
    logic [NUM_BANKS*3-1:0]    bank_src_lane_i;
    logic                      vlsu_rsp_valid_o;
    logic                      vlsu_rsp_ready_i;
    logic [NUM_LANES*64-1:0]   vlsu_rsp_data_o;
    logic [NUM_LANES-1:0]      vlsu_rsp_mask_o;
    logic [NUM_LANES-1:0]      lane_recv_o;
    logic                      err_o;

    modport master (
        output arm_i, arm_lane_valid_i, arm_lane_we_i, arm_lane_off_i,
               arm_lane_size_i, arm_lane_signed_i, bank_rvalid_i, bank_rdata_i,
               bank_src_lane_i, vlsu_rsp_ready_i,
        input  arm_ready_o, vlsu_rsp_valid_o, vlsu_rsp_data_o, vlsu_rsp_mask_o,
               lane_recv_o, err_o
    );

    modport slave (
        input  arm_i, arm_lane_valid_i, arm_lane_we_i, arm_lane_off_i,
               arm_lane_size_i, arm_lane_signed_i, bank_rvalid_i, bank_rdata_i,
               bank_src_lane_i, vlsu_rsp_ready_i,
        output arm_ready_o, vlsu_rsp_valid_o, vlsu_rsp_data_o, vlsu_rsp_mask_o,
               lane_recv_o, err_o
    );
endinterface

// File: rtl/rv64g_l1_resp_gather.sv
// Gathers per-bank responses back into their source lanes, aligns and extends
// load data, and hands one assembled vector response to the VLSU.
module rv64g_l1_resp_gather #(
    parameter int NUM_LANES = 8,
    parameter int NUM_BANKS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    rv64g_l1_resp_gather_if.slave bus
);
    localparam int LW = 3;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic [NUM_LANES-1:0]   mask_q, mask_d, we_q, we_d, sgn_q, sgn_d, recv_q, recv_d;
    logic [NUM_LANES*3-1:0] off_q, off_d;
    logic [NUM_LANES*2-1:0] size_q, size_d;
    logic [63:0]            data_q [NUM_LANES];
    logic [63:0]            data_d [NUM_LANES];
    logic                   err_q, err_d;
    logic [LW-1:0]          src;

    function automatic logic [63:0] align_data(input logic [63:0] raw, input logic [2:0] off,
                                               input logic [1:0] size, input logic sgn);
        logic [63:0] sh;
        sh = raw >> {off, 3'b000};
        unique case (size)
            2'd0:    align_data = {{56{sgn & sh[7]}},  sh[7:0]};
            2'd1:    align_data = {{48{sgn & sh[15]}}, sh[15:0]};
            2'd2:    align_data = {{32{sgn & sh[31]}}, sh[31:0]};
            default: align_data = sh;
        endcase
    endfunction

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        we_d    = we_q;
        sgn_d   = sgn_q;
        off_d   = off_q;
        size_d  = size_q;
        recv_d  = recv_q;
        data_d  = data_q;
        err_d   = err_q;
        src     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.arm_i) begin
                    mask_d  = bus.arm_lane_valid_i;
                    we_d    = bus.arm_lane_we_i;
                    sgn_d   = bus.arm_lane_signed_i;
                    off_d   = bus.arm_lane_off_i;
                    size_d  = bus.arm_lane_size_i;
                    recv_d  = '0;
                    err_d   = 1'b0;
                    for (int l = 0; l < NUM_LANES; l++) data_d[l] = '0;
                    state_d = (|bus.arm_lane_valid_i) ? S_COLLECT : S_RESP;
                end
                // A stray response in the arming cycle still counts against the new transaction.
                if (|bus.bank_rvalid_i) err_d = 1'b1;
            end
            S_COLLECT: begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (bus.bank_rvalid_i[b]) begin
                        src = bus.bank_src_lane_i[b*LW +: LW];
                        // recv_d already carries lanes claimed by lower banks this cycle.
                        if (mask_q[src] && !recv_d[src]) begin
                            recv_d[src] = 1'b1;
                            data_d[src] = we_q[src] ? 64'd0
                                        : align_data(bus.bank_rdata_i[b*64 +: 64],
                                                     off_q[int'(src)*3 +: 3],
                                                     size_q[int'(src)*2 +: 2], sgn_q[src]);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                if (recv_d == mask_q) state_d = S_RESP;
            end
            S_RESP: begin
                if (|bus.bank_rvalid_i) err_d = 1'b1;
                if (bus.vlsu_rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the data buffer is reset because its contents are visible on the response port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            we_q    <= '0;
            sgn_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            recv_q  <= '0;
            err_q   <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) data_q[l] <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            we_q    <= we_d;
            sgn_q   <= sgn_d;
            off_q   <= off_d;
            size_q  <= size_d;
            recv_q  <= recv_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign bus.arm_ready_o      = (state_q == S_IDLE);
    assign bus.vlsu_rsp_valid_o = (state_q == S_RESP);
    assign bus.vlsu_rsp_mask_o  = mask_q;
    assign bus.lane_recv_o      = recv_q;
    assign bus.err_o            = err_q;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_data
        assign bus.vlsu_rsp_data_o[l*64 +: 64] = data_q[l];
    end
endmodule

// File: tb/tb_rv64g_l1_resp_gather.sv
// Randomized plus directed bench for the response gather, checked every cycle
// against a transaction-level model of the collect/respond behaviour.
module tb_rv64g_l1_resp_gather;
    logic clk;
    logic rst_n;

    rv64g_l1_resp_gather_if #(.NUM_LANES(8), .NUM_BANKS(8)) bus ();

    rv64g_l1_resp_gather #(.NUM_LANES(8), .NUM_BANKS(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_phase;          // 0 waiting for arm, 1 gathering, 2 offering response
    logic [7:0]  m_mask, m_we, m_sgn, m_recv;
    logic [23:0] m_off;
    logic [15:0] m_size;
    logic [63:0] m_data [8];
    logic        m_err;

    function automatic logic [63:0] expect_lane(input logic [63:0] raw, input int off,
                                                input int size, input bit sgn, input bit we);
        int          nbits;
        logic [63:0] v;
        if (we) return 64'd0;
        nbits = 8 << size;
        v = raw >> (off * 8);
        if (nbits < 64) begin
            v = v & ((64'd1 << nbits) - 64'd1);
            if (sgn && v[nbits-1]) v = v - (64'd1 << nbits);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_mask = '0; m_we = '0; m_sgn = '0; m_recv = '0;
        m_off = '0; m_size = '0; m_err = 1'b0;
        for (int l = 0; l < 8; l++) m_data[l] = '0;
    endtask

    task automatic model_step();
        int lane;
        if (m_phase == 0) begin
            if (bus.arm_i) begin
                m_mask = bus.arm_lane_valid_i; m_we = bus.arm_lane_we_i;
                m_sgn = bus.arm_lane_signed_i; m_off = bus.arm_lane_off_i;
                m_size = bus.arm_lane_size_i; m_recv = '0; m_err = 1'b0;
                for (int l = 0; l < 8; l++) m_data[l] = '0;
                m_phase = (m_mask != 0) ? 1 : 2;
            end
            if (bus.bank_rvalid_i != 0) m_err = 1'b1;
        end else if (m_phase == 1) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.bank_rvalid_i[b]) begin
                    lane = int'(bus.bank_src_lane_i[b*3 +: 3]);
                    if (m_mask[lane] && !m_recv[lane]) begin
                        m_recv[lane] = 1'b1;
                        m_data[lane] = expect_lane(bus.bank_rdata_i[b*64 +: 64],
                                                   int'(m_off[lane*3 +: 3]), int'(m_size[lane*2 +: 2]),
                                                   m_sgn[lane], m_we[lane]);
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            if (m_recv == m_mask) m_phase = 2;
        end else begin
            if (bus.bank_rvalid_i != 0) m_err = 1'b1;
            if (bus.vlsu_rsp_ready_i) m_phase = 0;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check("arm_ready", bus.arm_ready_o, m_phase == 0);
            check("rsp_valid", bus.vlsu_rsp_valid_o, m_phase == 2);
            check("rsp_mask", bus.vlsu_rsp_mask_o, m_mask);
            check("lane_recv", bus.lane_recv_o, m_recv);
            check("err", bus.err_o, m_err);
            for (int l = 0; l < 8; l++)
                check($sformatf("data%0d", l), bus.vlsu_rsp_data_o[l*64 +: 64], m_data[l]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.arm_i = 1'b0; bus.bank_rvalid_i = '0; bus.bank_src_lane_i = '0;
        bus.bank_rdata_i = '0; bus.vlsu_rsp_ready_i = 1'b0;
    endtask

    task automatic arm(input logic [7:0] mask, input logic [7:0] we, input logic [7:0] sgn,
                       input logic [2:0] off, input logic [1:0] size);
        bus.arm_lane_valid_i = mask; bus.arm_lane_we_i = we; bus.arm_lane_signed_i = sgn;
        for (int l = 0; l < 8; l++) begin
            bus.arm_lane_off_i[l*3 +: 3]  = off;
            bus.arm_lane_size_i[l*2 +: 2] = size;
        end
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
    endtask

    task automatic put_bank(input int b, input logic [2:0] lane, input logic [63:0] data);
        bus.bank_rvalid_i[b] = 1'b1;
        bus.bank_src_lane_i[b*3 +: 3] = lane;
        bus.bank_rdata_i[b*64 +: 64] = data;
    endtask

    task automatic drain();
        bus.vlsu_rsp_ready_i = 1'b1;
        for (int i = 0; i < 20 && bus.arm_ready_o !== 1'b1; i++) tick();
        bus.vlsu_rsp_ready_i = 1'b0;
        check("drain_returns_idle", bus.arm_ready_o, 1'b1);
    endtask

    function automatic logic [63:0] lane_out(input int l);
        return bus.vlsu_rsp_data_o[l*64 +: 64];
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [511:0] snap;
        logic [7:0]   pend;
        int           cyc, pick;
        rst_n = 1'b0;
        clear_inputs();
        bus.arm_lane_valid_i = '0; bus.arm_lane_we_i = '0; bus.arm_lane_signed_i = '0;
        bus.arm_lane_off_i = '0; bus.arm_lane_size_i = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("reset_arm_ready", bus.arm_ready_o, 1'b1);
        check("reset_valid", bus.vlsu_rsp_valid_o, 1'b0);
        rst_n = 1'b1;

        // All eight lanes, doubleword loads, all banks in one cycle.
        arm(8'hFF, 8'h00, 8'h00, 3'd0, 2'd3);
        for (int b = 0; b < 8; b++) put_bank(b, 3'(b), 64'h1111_0000_0000_0000 | 64'(b));
        tick();
        clear_inputs();
        check("t1_valid", bus.vlsu_rsp_valid_o, 1'b1);
        for (int b = 0; b < 8; b++)
            check($sformatf("t1_lane%0d", b), lane_out(b), 64'h1111_0000_0000_0000 | 64'(b));
        check("t1_err", bus.err_o, 1'b0);
        drain();

        // Lanes 0..3 over three cycles, then backpressure.
        arm(8'h0F, 8'h00, 8'h00, 3'd0, 2'd3);
        put_bank(0, 3'd0, 64'hA0); put_bank(1, 3'd1, 64'hA1); tick(); clear_inputs();
        put_bank(4, 3'd2, 64'hA2); tick(); clear_inputs();
        check("t2_not_yet_valid", bus.vlsu_rsp_valid_o, 1'b0);
        put_bank(6, 3'd3, 64'hA3); tick(); clear_inputs();
        snap = bus.vlsu_rsp_data_o;
        for (int i = 0; i < 4; i++) begin
            bus.arm_i = 1'b1;
            tick();
            bus.arm_i = 1'b0;
            check("t2_hold_valid", bus.vlsu_rsp_valid_o, 1'b1);
            check("t2_hold_ready", bus.arm_ready_o, 1'b0);
            check("t2_hold_data", 64'(bus.vlsu_rsp_data_o != snap), 64'd0);
        end
        check("t2_lane2", lane_out(2), 64'hA2);
        drain();

        // Byte load at offset 5, signed then unsigned.
        arm(8'h04, 8'h00, 8'h04, 3'd5, 2'd0);
        put_bank(0, 3'd2, 64'h0000_8000_0000_0000); tick(); clear_inputs();
        check("t3_signed", lane_out(2), 64'hFFFF_FFFF_FFFF_FF80);
        drain();
        arm(8'h04, 8'h00, 8'h00, 3'd5, 2'd0);
        put_bank(0, 3'd2, 64'h0000_8000_0000_0000); tick(); clear_inputs();
        check("t3_unsigned", lane_out(2), 64'h80);
        drain();

        // Store lane ack.
        arm(8'h02, 8'h02, 8'h00, 3'd0, 2'd3);
        put_bank(7, 3'd1, 64'hDEAD); tick(); clear_inputs();
        check("t4_store_data", lane_out(1), 64'd0);
        check("t4_recv", bus.lane_recv_o, 8'h02);
        drain();

        // Lane collision and an unarmed lane.
        arm(8'h11, 8'h00, 8'h00, 3'd0, 2'd3);
        put_bank(3, 3'd4, 64'h3333); put_bank(5, 3'd4, 64'h5555); tick(); clear_inputs();
        put_bank(2, 3'd6, 64'h6666); tick(); clear_inputs();
        put_bank(0, 3'd0, 64'h0101); tick(); clear_inputs();
        check("t5_lane4", lane_out(4), 64'h3333);
        check("t5_lane6", lane_out(6), 64'd0);
        check("t5_err", bus.err_o, 1'b1);
        check("t5_recv", bus.lane_recv_o, 8'h11);
        drain();

        // Zero mask, then reset mid-collect.
        arm(8'h00, 8'h00, 8'h00, 3'd0, 2'd3);
        check("t6_zero_valid", bus.vlsu_rsp_valid_o, 1'b1);
        check("t6_zero_mask", bus.vlsu_rsp_mask_o, 8'h00);
        drain();
        arm(8'hFF, 8'h00, 8'h00, 3'd0, 2'd3);
        put_bank(1, 3'd1, 64'hBEEF); put_bank(2, 3'd1, 64'hF00D); tick(); clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_ready", bus.arm_ready_o, 1'b1);
        check("t6_rst_valid", bus.vlsu_rsp_valid_o, 1'b0);
        check("t6_rst_data", 64'(bus.vlsu_rsp_data_o != '0), 64'd0);
        check("t6_rst_mask", bus.vlsu_rsp_mask_o, 8'h00);
        check("t6_rst_recv", bus.lane_recv_o, 8'h00);
        check("t6_rst_err", bus.err_o, 1'b0);
        tick();
        rst_n = 1'b1;

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                put_bank($urandom_range(0, 7), 3'($urandom_range(0, 7)), {$urandom, $urandom});
                tick(); clear_inputs();
            end
            bus.arm_lane_valid_i  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            bus.arm_lane_we_i     = 8'($urandom);
            bus.arm_lane_signed_i = 8'($urandom);
            bus.arm_lane_off_i    = 24'($urandom);
            bus.arm_lane_size_i   = 16'($urandom);
            bus.arm_i = 1'b1;
            tick();
            cyc = 0;
            while (m_phase != 0 && cyc < 200) begin
                clear_inputs();
                pend = m_mask & ~m_recv;
                for (int b = 0; b < 8; b++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pick = $urandom_range(0, 7);
                        if (pend != 0 && $urandom_range(0, 4) != 0)
                            for (int k = 0; k < 8 && !pend[pick]; k++) pick = (pick + 1) % 8;
                        put_bank(b, 3'(pick), {$urandom, $urandom});
                    end
                end
                bus.vlsu_rsp_ready_i = 1'($urandom);
                bus.arm_i = ($urandom_range(0, 3) == 0);
                bus.arm_lane_valid_i = 8'($urandom);
                tick();
                cyc++;
            end
            clear_inputs();
            check("rand_txn_done", bus.arm_ready_o, 1'b1);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
